// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC owner, single-outstanding fetch FSM, segment-limit trap.
// Optional REQ-phase abort with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W         = 20,
    parameter int unsigned       INSTR_W        = 20,
    parameter logic [ADDR_W-1:0] RESET_PC       = 20'h00000,
    parameter logic [ADDR_W-1:0] SEG_LIMIT      = 20'h0FFFF,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_enable,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_busy,
    output logic               mem_violation_flag,
    output logic               fetch_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [INSTR_W-1:0] TRAP = '0;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pend_pc_q;
    logic                pend_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                valid_q;
    logic                viol_q;

    logic [ADDR_W-1:0]   fetch_addr_d;
    logic [ADDR_W-1:0]   pc_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_q;
    logic          tmo_q;
`endif

    assign fetch_addr_d = pc_load ? pc_target : pc_q;

    // A jump arriving in the ack cycle beats an older pending one.
    assign pc_d = pc_load ? pc_target :
                  pend_q  ? pend_pc_q :
                            pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            pend_q     <= 1'b0;
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= 1'b0;
            viol_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tcnt_q     <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (fetch_enable) begin
                        if (fetch_addr_d > SEG_LIMIT) begin
                            viol_q  <= 1'b1;
                            instr_q <= TRAP;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_addr_d;
                            pc_q       <= fetch_addr_d;
                            state_q    <= REQ;
`ifdef FETCH_TIMEOUT_EN
                            tcnt_q     <= '0;
`endif
                        end
                    end else if (pc_load) begin
                        pc_q <= pc_target;
                    end
                end
                REQ: begin
                    if (pc_load) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= pc_target;
                    end
                    if (mem_ack) begin
                        instr_q   <= mem_rdata;
                        mem_req_q <= 1'b0;
                        pc_q      <= pc_d;
                        pend_q    <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Abort leaves pc alone; any pending jump lands in DONE.
                    else if (tcnt_q == TLAST) begin
                        mem_req_q <= 1'b0;
                        instr_q   <= TRAP;
                        tmo_q     <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    pend_q  <= 1'b0;
                    if (pc_load) begin
                        pc_q <= pc_target;
                    end else if (pend_q) begin
                        pc_q <= pend_pc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req            = mem_req_q;
    assign mem_addr           = mem_addr_q;
    assign instruction        = instr_q;
    assign instr_valid        = valid_q;
    assign pc                 = pc_q;
    assign fetch_busy         = (state_q != IDLE);
    assign mem_violation_flag = viol_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_timeout      = tmo_q;
`else
    assign fetch_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetches, scoreboard-checked deliveries.
// Memory responder returns 20'h4C123 ^ addr after a programmable wait.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [19:0] instr;
        logic [19:0] pc;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fe, pl;
    logic [19:0] pt;
    logic        mreq;
    logic [19:0] maddr;
    logic        mack;
    logic [19:0] mrd;
    logic [19:0] instr;
    logic        ivalid;
    logic [19:0] pc;
    logic        busy, viol, tmo;

    logic        wfe, wack;
    logic [19:0] wrd;
    logic        wreq;
    logic [19:0] waddr, winstr, wpc;
    logic        wvalid, wbusy, wviol, wtmo;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    int   ack_delay = 0;
    logic no_ack = 1'b0;
    logic late_ack = 1'b0;
    int   wcnt = 0;
    logic acked = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_enable(fe), .pc_load(pl),
        .pc_target(pt), .mem_req(mreq), .mem_addr(maddr), .mem_ack(mack),
        .mem_rdata(mrd), .instruction(instr), .instr_valid(ivalid), .pc(pc),
        .fetch_busy(busy), .mem_violation_flag(viol), .fetch_timeout(tmo)
    );

    instr_fetch_unit #(
        .RESET_PC(20'hFFFFF), .SEG_LIMIT(20'hFFFFF)
    ) dut_w (
        .clk(clk), .reset(reset), .fetch_enable(wfe), .pc_load(1'b0),
        .pc_target(20'h00000), .mem_req(wreq), .mem_addr(waddr), .mem_ack(wack),
        .mem_rdata(wrd), .instruction(winstr), .instr_valid(wvalid), .pc(wpc),
        .fetch_busy(wbusy), .mem_violation_flag(wviol), .fetch_timeout(wtmo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder
    always @(negedge clk) begin
        if (late_ack) begin
            mack <= 1'b1;
            mrd  <= 20'h12345;
        end else if (mreq && !acked) begin
            if (!no_ack && wcnt == ack_delay) begin
                mack  <= 1'b1;
                mrd   <= 20'h4C123 ^ maddr;
                acked <= 1'b1;
            end else begin
                mack <= 1'b0;
                wcnt <= wcnt + 1;
            end
        end else begin
            mack <= 1'b0;
            if (!mreq) begin
                wcnt  <= 0;
                acked <= 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!reset && ivalid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: instr=%h pc=%h expected none", instr, pc);
            end else begin
                mon_e = sb.pop_front();
                chk("deliv_instr", 32'(instr), 32'(mon_e.instr));
                chk("deliv_pc", 32'(pc), 32'(mon_e.pc));
                chk("deliv_tmo", 32'(tmo), 32'(mon_e.to));
            end
        end
    end

    task automatic strobe(input logic load, input logic [19:0] tgt);
        @(negedge clk);
        fe = 1'b1;
        pl = load;
        pt = tgt;
        @(negedge clk);
        fe = 1'b0;
        pl = 1'b0;
    endtask

    task automatic expect_d(input logic [19:0] i, input logic [19:0] p, input logic t);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.to    = t;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || sb.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 32'(busy || sb.size() != 0), 32'd0);
    endtask

    task automatic idle_load(input logic [19:0] tgt);
        @(negedge clk);
        pl = 1'b1;
        pt = tgt;
        @(negedge clk);
        pl = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        fe = 1'b0; pl = 1'b0; pt = '0;
        wfe = 1'b0; wack = 1'b0; wrd = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_outs", {26'd0, mreq, ivalid, busy, viol, tmo, |maddr}, 32'h0);
        chk("rst_wpc", 32'(wpc), 32'hFFFFF);
        reset = 1'b0;

        // Zero-wait fetch
        ack_delay = 0;
        expect_d(20'h4C123, 20'h00001, 1'b0);
        strobe(1'b0, 20'h0);
        chk("t1_req", 32'(mreq), 32'd1);
        chk("t1_addr", 32'(maddr), 32'h0);
        @(negedge clk);
        chk("t1_latency", 32'(ivalid), 32'd1);
        wait_idle();

        // Delayed ack, extra strobes ignored
        ack_delay = 5;
        expect_d(20'h4C122, 20'h00002, 1'b0);
        strobe(1'b0, 20'h0);
        chk("t2_req0", {11'd0, mreq, maddr}, {11'd0, 1'b1, 20'h00001});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) fe = 1'b1;
            if (i == 3) fe = 1'b0;
            chk("t2_req_stable", {11'd0, mreq, maddr}, {11'd0, 1'b1, 20'h00001});
        end
        wait_idle();

        // Jumps during REQ: later one replaces earlier
        ack_delay = 3;
        expect_d(20'h4C121, 20'h00200, 1'b0);
        strobe(1'b0, 20'h0);
        pl = 1'b1; pt = 20'h00300;
        @(negedge clk);
        pt = 20'h00200;
        @(negedge clk);
        pl = 1'b0;
        wait_idle();
        chk("t3_pc", 32'(pc), 32'h00200);
        ack_delay = 0;
        expect_d(20'h4C323, 20'h00201, 1'b0);
        strobe(1'b0, 20'h0);
        chk("t3_addr", 32'(maddr), 32'h00200);
        wait_idle();

        // Jump in IDLE, then jump+fetch same cycle
        idle_load(20'h00ABC);
        chk("idle_load_pc", 32'(pc), 32'h00ABC);
        expect_d(20'h4C173, 20'h00051, 1'b0);
        strobe(1'b1, 20'h00050);
        chk("jf_addr", 32'(maddr), 32'h00050);
        wait_idle();

        // Segment limit boundary: last legal address
        expect_d(20'h43EDC, 20'h10000, 1'b0);
        strobe(1'b1, 20'h0FFFF);
        chk("lim_addr", 32'(maddr), 32'h0FFFF);
        wait_idle();
        chk("lim_noviol", 32'(viol), 32'd0);

        // pc itself beyond limit
        expect_d(20'h00000, 20'h10000, 1'b0);
        strobe(1'b0, 20'h0);
        chk("viol_noreq", 32'(mreq), 32'd0);
        chk("viol_flag", 32'(viol), 32'd1);
        wait_idle();

        // Jump target beyond limit with fetch
        idle_load(20'h00010);
        expect_d(20'h00000, 20'h00010, 1'b0);
        strobe(1'b1, 20'h10000);
        chk("t4_noreq", 32'(mreq), 32'd0);
        wait_idle();
        chk("t4_pc", 32'(pc), 32'h00010);
        expect_d(20'h4C133, 20'h00011, 1'b0);
        strobe(1'b0, 20'h0);
        wait_idle();
        chk("t4_sticky", 32'(viol), 32'd1);

        no_ack = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        expect_d(20'h00000, 20'h00011, 1'b1);
        strobe(1'b0, 20'h0);
        n = 0;
        for (int k = 0; k < 40 && !tmo; k++) begin
            if (mreq) n++;
            @(negedge clk);
        end
        chk("t6_req_cycles", 32'(n), 32'd16);
        wait_idle();
        chk("t6_pc", 32'(pc), 32'h00011);
        strobe(1'b0, 20'h0);
        repeat (3) @(negedge clk);
`else
        strobe(1'b0, 20'h0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (mreq && !tmo) n++;
            @(negedge clk);
        end
        chk("wait_forever", 32'(n), 32'd20);
`endif

        // Reset mid-REQ
        #2 reset = 1'b1;
        #1;
        chk("midrst_req", 32'(mreq), 32'd0);
        chk("midrst_state", {28'd0, busy, viol, ivalid, tmo}, 32'h0);
        chk("midrst_pc", 32'(pc), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        no_ack = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        @(negedge clk);
        chk("late_ack", {11'd0, busy, instr}, 32'h0);

        // Wrap instance: PC rolls over
        @(negedge clk);
        wfe = 1'b1;
        @(negedge clk);
        wfe = 1'b0;
        chk("t5_addr", {11'd0, wreq, waddr}, {11'd0, 1'b1, 20'hFFFFF});
        wack = 1'b1;
        wrd = 20'hB3EDC;
        @(negedge clk);
        wack = 1'b0;
        chk("t5_deliv", {11'd0, wvalid, winstr}, {11'd0, 1'b1, 20'hB3EDC});
        chk("t5_wrap", 32'(wpc), 32'h0);
        chk("t5_noviol", 32'(wviol), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
